// File: rtl/wb_burst_master.sv
// wb_burst_master: turns a command/data stream into incrementing-burst
// Wishbone B3 cycles for the SDRAM controller's slave port.
// A command is accepted in IDLE. The bus is driven only in BURST, and the
// FSM returns to IDLE on the edge after the final ack.
// Optional feature macro: WB_MASTER_TIMEOUT_EN. When it is defined, a per-beat
// ack watchdog aborts the burst after TIMEOUT unacked strobe cycles.
module wb_burst_master #(
   parameter int dw      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              sys_clk,
   input  logic              RESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [25:0]       cmd_addr,
   input  logic              cmd_we,
   input  logic [7:0]        cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [dw-1:0]     wr_data,
   output logic              rd_valid,
   output logic [dw-1:0]     rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic [25:0]       wb_addr_o,
   output logic              wb_we_o,
   output logic [dw-1:0]     wb_dat_o,
   output logic [dw/8-1:0]   wb_sel_o,
   output logic [2:0]        wb_cti_o,
   input  logic [dw-1:0]     wb_dat_i,
   input  logic              wb_ack_i
);

   localparam int SW = dw / 8;

   // Reject unusable parameter values at elaboration time.
   if ((dw % 8) != 0 || dw < 8 || TIMEOUT < 2) begin : g_bad_param
      $error("wb_burst_master: dw must be a multiple of 8 and TIMEOUT >= 2");
   end

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [25:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        done_q, done_d;

   logic in_burst;
   logic stb;
   logic beat;
   logic last;
   logic to_hit;

   assign in_burst = (state_q == BURST);
   // Reads strobe every cycle. Writes strobe only when data is offered, so an
   // empty write stream inserts master wait states while cyc stays high.
   assign stb      = in_burst & (wr_valid | ~we_q);
   // An ack with stb low is not a beat.
   assign beat     = stb & wb_ack_i;
   assign last     = (cnt_q == len_q);

`ifdef WB_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] to_q, to_d;
   logic          err_q, err_d;

   // The TIMEOUT-th consecutive unacked strobe cycle triggers the abort.
   assign to_hit = stb & ~wb_ack_i & (to_q == TW'(TIMEOUT - 1));

   // Watchdog next state: count unacked strobe cycles and hold during wait
   // states. The count clears on an ack, on an abort, and outside a burst.
   always_comb begin
      to_d  = to_q;
      err_d = to_hit;
      if (!in_burst || beat || to_hit)
         to_d = '0;
      else if (stb)
         to_d = to_q + 1'b1;
   end

   // Watchdog registers.
   always_ff @(posedge sys_clk) begin
      if (RESET) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign to_hit = 1'b0;
   assign err    = 1'b0;
`endif

   // Control state register.
   always_ff @(posedge sys_clk) begin
      if (RESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: latch the command in IDLE, then advance one beat per ack.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = BURST;
               addr_d  = cmd_addr;
               we_d    = cmd_we;
               len_d   = cmd_len;
               cnt_d   = '0;
            end
         end
         BURST: begin
            if (to_hit) begin
               // Abort: the remaining beats are dropped and no done pulse is sent.
               state_d = IDLE;
            end else if (beat) begin
               // The 26-bit address wraps naturally modulo 2^26.
               addr_d = addr_q + 26'(SW);
               cnt_d  = cnt_q + 8'd1;
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus and stream outputs. Qualifiers are gated by cyc so that everything
   // reads 0 out of reset and while idle.
   always_comb begin
      cmd_ready = ~in_burst;
      busy      = in_burst;
      done      = done_q;
      wb_cyc_o  = in_burst;
      wb_stb_o  = stb;
      wb_addr_o = addr_q;
      wb_we_o   = in_burst & we_q;
      wb_dat_o  = (in_burst & we_q) ? wr_data : '0;
      wb_sel_o  = {SW{in_burst}};
      wb_cti_o  = 3'b000;
      if (in_burst && len_q != 8'd0)
         wb_cti_o = last ? 3'b111 : 3'b010;
      wr_ready  = beat & we_q;
      rd_valid  = beat & ~we_q;
      rd_data   = (beat & ~we_q) ? wb_dat_i : '0;
   end

endmodule
